pool_upsampler_2x2: RTL and testbench
=====================================

# pool_upsampler_2x2

- Nearest-neighbour 2x upsampler; the inverse of the 2x2 pooling stage.
- Consumes a pooled feature map of IN_H x IN_W signed 16-bit pixels, row-major, over a valid/ready stream.
- Emits the 2*IN_H x 2*IN_W upsampled map, row-major, with each input pixel replicated into a 2x2 block.
- Sits on the decoder/expansion path of the CNN. Uses the same level-sensitive start/finish frame handshake as the pooling engine.

## Interface
- IN_W, default 14: pooled row width in pixels (≥1).
- IN_H, default 14: pooled row count (≥1).
- DATA_W, default 16: pixel width, signed (shortint).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level. Frame begins when high in IDLE; must stay high until finish is seen.
- in_valid  in  1  input pixel valid.
- in_data  in  DATA_W  pooled pixel, signed.
- in_ready  out  1  input accepted when in_valid && in_ready.
- out_valid  out  1  output pixel valid.
- out_data  out  DATA_W  upsampled pixel, signed.
- out_ready  in  1  output consumed when out_valid && out_ready.
- finish  out  1  high in DONE; held until start drops.

## Operation
- FSM states: IDLE, ROW_A, ROW_B, DONE.
- **IDLE**
  - start=1 moves to ROW_A.
  - Row and column counters clear.
- **ROW_A** (first output row of pooled row r)
  - Each accepted input pixel c is written to line_buf[c] and loaded into the output register with copy=0.
  - The output register presents the pixel for two consecutive output beats (copy 0, then copy 1).
  - in_ready = !out_valid || (out_ready && copy==1).
  - After pixel IN_W-1 has been accepted and its copy-1 beat consumed, go to ROW_B with col=0.
- **ROW_B** (second output row of pooled row r)
  - Replays line_buf[0..IN_W-1] with the same duplication. in_ready=0.
  - After the last copy-1 beat is consumed:
    - r<IN_H-1: r++, go to ROW_A.
    - otherwise go to DONE.
- **DONE**
  - finish=1, out_valid=0, in_ready=0.
  - When start=0, go to IDLE; finish drops in the same transition.
- Data is a pure copy, no arithmetic. Sign and all DATA_W bits are preserved.
- Counters:
  - col: $clog2(IN_W) bits, min 1.
  - row: $clog2(IN_H) bits, min 1.
  - copy: 1 bit.
  - All wrap to 0 at row end.
- start toggling while busy is ignored. Only the IDLE state samples it.
- Reset, including mid-frame, forces IDLE:
  - in_ready=0, out_valid=0, out_data=0, finish=0.
  - All counters are cleared.
  - line_buf contents are don't-care.

## Timing
- Input accepted at edge t → out_valid=1 with that pixel from edge t+1 (latency 1).
- Full throughput: one output beat per cycle when out_ready=1 and input is available.
  - Input rate is half of output rate in ROW_A.
  - Input rate is zero in ROW_B.
- out_ready=0: out_data and out_valid hold, and copy does not advance.
- in_valid gaps: out_valid deasserts after the pending copy-1 beat drains. No duplicate or lost beats.
- ROW_B's first beat is valid the cycle after ROW_A's last beat is consumed (no bubble required, one allowed).
- finish rises the cycle after the final output beat is consumed. It falls the cycle after start is sampled low.
- IN_W=1: each row is 2 beats. IN_H=1: a single ROW_A/ROW_B pair, then DONE.

## Structure
- Package pool_pkg holds:
  - the pixel_t typedef (logic signed [15:0]);
  - the state enum {IDLE, ROW_A, ROW_B, DONE};
  - the default IN_W/IN_H constants.
- One sub-module: pool_line_buffer.
  - IN_W x DATA_W, 1 write port and 1 read port.
  - Synchronous write, combinational read.
  - Instanced once.
- FSM, counters and output register live in the top module.

## Test plan
- **Basic 2x2 map:** IN_W=2, IN_H=2, input 1,2,3,4, out_ready=1 → output 1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4; finish=1 one cycle after the 16th beat.
- **Backpressure and input gaps:** same map, out_ready random 50%, in_valid gaps → identical 16-beat sequence; out_data stable whenever out_valid && !out_ready.
- **Sign/extremes:** inputs -32768, 32767, -1, 0 → each appears exactly four times in 2x2 blocks with bit-exact values.
- **Finish handshake:** start held high after DONE → finish stays 1; start=0 → finish=0 next cycle; a new start runs a second frame correctly.
- **Reset mid-frame:** rst_n=0 during ROW_B of row 0 → outputs 0 immediately; after release and a new start, the full frame is correct.
- **Degenerate size:** IN_W=1, IN_H=1, input 7 → 7,7,7,7, then finish.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types and defaults for the pooling / upsampling stages.
package pool_pkg;

  localparam int DEF_IN_W = 14;
  localparam int DEF_IN_H = 14;
  localparam int PIXEL_W  = 16;

  typedef logic signed [15:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROW_A = 2'd1,
    ROW_B = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/pool_line_buffer.sv
// One-row pixel store: synchronous write, combinational read.
// Holds the pooled row seen in ROW_A so ROW_B can replay it.
module pool_line_buffer #(
  parameter int DEPTH  = 14,
  parameter int DATA_W = 16,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [AW-1:0]            waddr_i,
  input  logic signed [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]            raddr_i,
  output logic signed [DATA_W-1:0] rdata_o
);

  logic signed [DATA_W-1:0] mem_q [DEPTH];

  // Row storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pool_upsampler_2x2.sv
// Nearest-neighbour 2x upsampler: every pooled pixel becomes a 2x2 block.
// ROW_A streams input pixels (each shown twice) while filling the line
// buffer; ROW_B replays the buffer to produce the duplicated row.
module pool_upsampler_2x2
  import pool_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int IN_H   = DEF_IN_H,
  parameter int DATA_W = PIXEL_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  input  logic                     out_ready,
  output logic                     finish
);

  localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int RW = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IN_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IN_H - 1);

  state_e                   state_q, state_d;
  logic [CW-1:0]            col_q, col_d;
  logic [RW-1:0]            row_q, row_d;
  logic                     copy_q, copy_d;
  // Set once the last pixel of the row has been taken in ROW_A.
  logic                     full_q, full_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;

  logic                     in_ready_c;
  logic                     fire_in;
  logic                     fire_out;
  logic                     buf_we;
  logic [CW-1:0]            buf_raddr;
  logic signed [DATA_W-1:0] buf_rdata;

  pool_line_buffer #(
    .DEPTH  (IN_W),
    .DATA_W (DATA_W),
    .AW     (CW)
  ) u_line_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (col_q),
    .wdata_i (in_data),
    .raddr_i (buf_raddr),
    .rdata_o (buf_rdata)
  );

  assign fire_out = out_valid_q && out_ready;

  // State register, counters and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      copy_q      <= 1'b0;
      full_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      copy_q      <= copy_d;
      full_q      <= full_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Next-state, counter and handshake logic.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    copy_d      = copy_q;
    full_d      = full_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    in_ready_c  = 1'b0;
    fire_in     = 1'b0;
    buf_we      = 1'b0;
    buf_raddr   = '0;

    case (state_q)
      IDLE: begin
        col_d       = '0;
        row_d       = '0;
        copy_d      = 1'b0;
        full_d      = 1'b0;
        out_valid_d = 1'b0;
        if (start) begin
          state_d = ROW_A;
        end
      end

      ROW_A: begin
        // A new pixel may replace the register only as its copy-1 beat leaves.
        in_ready_c = !full_q && (!out_valid_q || (out_ready && copy_q));
        fire_in    = in_valid && in_ready_c;
        if (fire_in) begin
          buf_we      = 1'b1;
          out_data_d  = in_data;
          out_valid_d = 1'b1;
          copy_d      = 1'b0;
          if (col_q == COL_LAST) begin
            col_d  = '0;
            full_d = 1'b1;
          end else begin
            col_d = col_q + CW'(1);
          end
        end else if (fire_out) begin
          if (!copy_q) begin
            copy_d = 1'b1;
          end else begin
            copy_d      = 1'b0;
            out_valid_d = 1'b0;
            if (full_q) begin
              // Preload buffer entry 0 so ROW_B starts without a bubble.
              full_d      = 1'b0;
              col_d       = '0;
              state_d     = ROW_B;
              out_valid_d = 1'b1;
              out_data_d  = buf_rdata;
            end
          end
        end
      end

      ROW_B: begin
        // Look one entry ahead: the register already holds entry col_q.
        buf_raddr = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
        if (fire_out) begin
          if (!copy_q) begin
            copy_d = 1'b1;
          end else begin
            copy_d = 1'b0;
            if (col_q == COL_LAST) begin
              col_d       = '0;
              out_valid_d = 1'b0;
              if (row_q == ROW_LAST) begin
                row_d   = '0;
                state_d = DONE;
              end else begin
                row_d   = row_q + RW'(1);
                state_d = ROW_A;
              end
            end else begin
              col_d      = col_q + CW'(1);
              out_data_d = buf_rdata;
            end
          end
        end
      end

      DONE: begin
        out_valid_d = 1'b0;
        if (!start) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign finish    = (state_q == DONE);

endmodule

// File: tb/tb_pool_upsampler_2x2.sv
// Directed bench for pool_upsampler_2x2: a 2x2 instance and a 1x1 instance.
module tb_pool_upsampler_2x2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               start_a, start_b;
  logic               in_valid, out_ready;
  logic signed [15:0] in_data;
  logic               ir_a, ov_a, fin_a, ir_b, ov_b, fin_b;
  logic signed [15:0] od_a, od_b;

  logic               sel;
  logic               ir, ov, fin;
  logic signed [15:0] od;

  int n_chk  = 0;
  int n_fail = 0;

  assign ir  = sel ? ir_b  : ir_a;
  assign ov  = sel ? ov_b  : ov_a;
  assign fin = sel ? fin_b : fin_a;
  assign od  = sel ? od_b  : od_a;

  pool_upsampler_2x2 #(.IN_W(2), .IN_H(2), .DATA_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_a),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (ir_a),
    .out_valid (ov_a),
    .out_data  (od_a),
    .out_ready (out_ready),
    .finish    (fin_a)
  );

  pool_upsampler_2x2 #(.IN_W(1), .IN_H(1), .DATA_W(16)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_b),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (ir_b),
    .out_valid (ov_b),
    .out_data  (od_b),
    .out_ready (out_ready),
    .finish    (fin_b)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives one frame from negedge to negedge and checks every output beat.
  // stop_after < total beats abandons the frame mid-way (for reset tests).
  task automatic run_frame(input bit s, input int w, input int h,
                           input int px[4], input bit rnd, input int stop_after);
    int exp_q[$];
    int idx, beats, cyc, target;
    logic hold;
    logic signed [15:0] held;
    for (int r = 0; r < h; r++)
      for (int rep = 0; rep < 2; rep++)
        for (int c = 0; c < w; c++) begin
          exp_q.push_back(px[r*w+c]);
          exp_q.push_back(px[r*w+c]);
        end
    target = (stop_after < exp_q.size()) ? stop_after : exp_q.size();
    idx = 0; beats = 0; cyc = 0; hold = 1'b0; held = '0;
    sel = s;
    if (s) start_b = 1'b1; else start_a = 1'b1;
    while (beats < target && cyc < 2000) begin
      in_valid  = (idx < w*h) && (!rnd || ($urandom_range(0, 1) == 1));
      in_data   = (idx < w*h) ? 16'(px[idx]) : 16'sd0;
      out_ready = !rnd || ($urandom_range(0, 1) == 1);
      #1;
      if (hold) begin
        check("hold_valid", ov, 1);
        check("hold_data", od, held);
      end
      if (ov && out_ready) begin
        check($sformatf("beat%0d", beats), od, exp_q[beats]);
        beats++;
      end
      hold = ov && !out_ready;
      held = od;
      if (in_valid && ir) idx++;
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("beat_count", beats, target);
    if (target == exp_q.size()) begin
      check("finish_rise", fin, 1);
      check("done_out_valid", ov, 0);
      check("done_in_ready", ir, 0);
    end
  endtask

  // Drops start and confirms finish falls one cycle later.
  task automatic end_frame(input bit s);
    @(negedge clk);
    if (s) start_b = 1'b0; else start_a = 1'b0;
    @(negedge clk);
    #1;
    check("finish_fall", fin, 0);
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0; sel = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", ir_a, 0);
    check("rst_out_valid", ov_a, 0);
    check("rst_out_data", od_a, 0);
    check("rst_finish", fin_a, 0);
    check("rst_finish_1x1", fin_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic 2x2 map, full throughput
    run_frame(1'b0, 2, 2, '{1, 2, 3, 4}, 1'b0, 100);

    // Finish held while start stays high
    repeat (3) @(negedge clk);
    #1;
    check("finish_held", fin_a, 1);
    check("finish_held_ov", ov_a, 0);
    end_frame(1'b0);

    // Second frame with random backpressure and input gaps
    @(negedge clk);
    run_frame(1'b0, 2, 2, '{1, 2, 3, 4}, 1'b1, 100);
    end_frame(1'b0);

    // Sign and extreme values
    @(negedge clk);
    run_frame(1'b0, 2, 2, '{-32768, 32767, -1, 0}, 1'b0, 100);
    end_frame(1'b0);

    // Reset during ROW_B of row 0 (fifth beat is the first ROW_B beat)
    @(negedge clk);
    run_frame(1'b0, 2, 2, '{9, 10, 11, 12}, 1'b0, 5);
    check("pre_rst_valid", ov_a, 1);
    rst_n   = 1'b0;
    start_a = 1'b0;
    #1;
    check("mid_rst_in_ready", ir_a, 0);
    check("mid_rst_out_valid", ov_a, 0);
    check("mid_rst_out_data", od_a, 0);
    check("mid_rst_finish", fin_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(1'b0, 2, 2, '{5, -6, 7, -8}, 1'b1, 100);
    end_frame(1'b0);

    // Degenerate 1x1 size
    @(negedge clk);
    run_frame(1'b1, 1, 1, '{7, 0, 0, 0}, 1'b0, 100);
    end_frame(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
